// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package display_pkg;
    localparam logic [3:0] SEG_SPACE  = 4'hd;
    localparam logic [3:0] SEG_ZERO   = 4'h0;
    localparam int         MAX_DIGITS = 8;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    // Wide enough for the largest supported digit count; low bits select the slot.
    typedef logic [$clog2(MAX_DIGITS)-1:0] slot_t;
endpackage

// File: rtl/display_scanner_if.sv
// Load/blank controls toward the scanner and scan outputs toward the decoder.
interface display_scanner_if #(parameter int NUM_DIGITS = 4);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_in;
    logic [3:0]              digit;
    logic                    decimal;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    pending;
    logic                    frame_done;

    modport master (output load, value_in, dp_in, blank_in,
                    input  digit, decimal, anode, pending, frame_done);
    modport slave  (input  load, value_in, dp_in, blank_in,
                    output digit, decimal, anode, pending, frame_done);
endinterface

// File: rtl/refresh_divider.sv
// Free-running 0..REFRESH_DIV-1 counter; tick is high during the terminal count.
module refresh_divider #(
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_WIDTH   = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(REFRESH_DIV - 1);

    logic [DIV_WIDTH-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || tick) cnt <= '0;
        else               cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/display_scanner.sv
// Multiplexed digit scanner with a double-buffered value committed at frame boundaries.
// Optional LEADING_ZERO_BLANK_EN: blank leading zeros when the shadow commits.
module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_WIDTH   = 16
) (
    input  logic              clk,
    input  logic              reset,
    display_scanner_if.slave  bus
);
    localparam int    IW        = $clog2(NUM_DIGITS);
    localparam slot_t LAST_SLOT = slot_t'(NUM_DIGITS - 1);

    logic tick, boundary;
    slot_t idx, idx_nxt;
    logic [NUM_DIGITS-1:0][3:0] act_code, act_code_nxt, shd_code;
    logic [NUM_DIGITS-1:0]      act_dp, act_dp_nxt, shd_dp;
    logic                       pending_q, frame_done_q, decimal_q;
    logic [3:0]                 digit_q;
    logic [NUM_DIGITS-1:0]      anode_q;

    refresh_divider #(.REFRESH_DIV(REFRESH_DIV), .DIV_WIDTH(DIV_WIDTH)) u_div (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; the first nonzero code or lit DP ends the blanking.
    function automatic logic [NUM_DIGITS-1:0][3:0] blank_leading(
        input logic [NUM_DIGITS-1:0][3:0] c, input logic [NUM_DIGITS-1:0] dp);
        logic [NUM_DIGITS-1:0][3:0] r;
        logic lead;
        r    = c;
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (dp[i] || c[i] != SEG_ZERO) lead = 1'b0;
            if (lead) r[i] = SEG_SPACE;
        end
        return r;
    endfunction
`endif

    always_comb begin
        boundary     = tick && (idx == LAST_SLOT);
        idx_nxt      = idx;
        act_code_nxt = act_code;
        act_dp_nxt   = act_dp;
        if (tick) idx_nxt = boundary ? '0 : idx + 1'b1;
        if (boundary && pending_q) begin
`ifdef LEADING_ZERO_BLANK_EN
            act_code_nxt = blank_leading(shd_code, shd_dp);
`else
            act_code_nxt = shd_code;
`endif
            act_dp_nxt   = shd_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            act_code     <= {NUM_DIGITS{SEG_SPACE}};
            shd_code     <= {NUM_DIGITS{SEG_SPACE}};
            act_dp       <= '0;
            shd_dp       <= '0;
            digit_q      <= SEG_SPACE;
            decimal_q    <= 1'b0;
            anode_q      <= ANODE_OFF[NUM_DIGITS-1:0];
        end else begin
            idx          <= idx_nxt;
            act_code     <= act_code_nxt;
            act_dp       <= act_dp_nxt;
            frame_done_q <= boundary;
            // A boundary-cycle load commits the old shadow above and keeps pending set.
            if (bus.load) begin
                shd_code  <= bus.value_in;
                shd_dp    <= bus.dp_in;
                pending_q <= 1'b1;
            end else if (boundary) begin
                pending_q <= 1'b0;
            end
            digit_q   <= act_code_nxt[idx_nxt[IW-1:0]];
            decimal_q <= act_dp_nxt[idx_nxt[IW-1:0]];
            anode_q   <= bus.blank_in ? ANODE_OFF[NUM_DIGITS-1:0]
                                      : ~(NUM_DIGITS'(1) << idx_nxt);
        end
    end

    assign bus.digit      = digit_q;
    assign bus.decimal    = decimal_q;
    assign bus.anode      = anode_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scanner.sv
// Random + directed stimulus against an edge-count reference model of the scanner.
module tb_display_scanner;
    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int DW    = 3;
    localparam int FRAME = ND * RD;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    display_scanner_if #(.NUM_DIGITS(ND)) bus();

    display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DIV_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference state: k counts non-reset edges since the last reset.
    int         k;
    logic [3:0] m_act [ND];
    logic [3:0] m_shd [ND];
    logic       m_adp [ND];
    logic       m_sdp [ND];
    logic       m_pend;
    logic [3:0] e_digit;
    logic       e_dec, e_fd;
    logic [ND-1:0] e_anode;
    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
    endtask

    // Highest digit holding a nonzero code or a lit DP; everything above it is leading.
    task automatic commit_shadow();
        int top;
        top = 0;
        for (int i = 0; i < ND; i++)
            if (m_shd[i] != 4'h0 || m_sdp[i]) top = i;
        for (int i = 0; i < ND; i++) begin
            m_adp[i] = m_sdp[i];
`ifdef LEADING_ZERO_BLANK_EN
            m_act[i] = (i > top) ? 4'hd : m_shd[i];
`else
            m_act[i] = m_shd[i];
`endif
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic [15:0] v,
                        input logic [3:0] d, input logic b);
        int slot;
        logic bnd;
        @(negedge clk);
        reset = r; bus.load = ld; bus.value_in = v; bus.dp_in = d; bus.blank_in = b;
        @(posedge clk);
        if (r) begin
            k = 0;
            for (int i = 0; i < ND; i++) begin
                m_act[i] = 4'hd; m_shd[i] = 4'hd; m_adp[i] = 1'b0; m_sdp[i] = 1'b0;
            end
            m_pend = 1'b0; e_digit = 4'hd; e_dec = 1'b0; e_anode = '1; e_fd = 1'b0;
        end else begin
            k++;
            bnd = (k % FRAME) == 0;
            if (bnd && m_pend) begin
                commit_shadow();
                m_pend = 1'b0;
            end
            if (ld) begin
                for (int i = 0; i < ND; i++) begin
                    m_shd[i] = v[4*i +: 4];
                    m_sdp[i] = d[i];
                end
                m_pend = 1'b1;
            end
            slot    = (k / RD) % ND;
            e_digit = m_act[slot];
            e_dec   = m_adp[slot];
            for (int j = 0; j < ND; j++) e_anode[j] = b || (j != slot);
            e_fd    = bnd;
        end
        #1;
        check("digit",      32'(bus.digit),      32'(e_digit));
        check("decimal",    32'(bus.decimal),    32'(e_dec));
        check("anode",      32'(bus.anode),      32'(e_anode));
        check("pending",    32'(bus.pending),    32'(m_pend));
        check("frame_done", 32'(bus.frame_done), 32'(e_fd));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    task automatic to_phase(input int p);
        for (int i = 0; i < FRAME && (k % FRAME) != p; i++) idle(1);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        step(1'b0, 1'b1, v, d, 1'b0);
    endtask

    initial begin
        reset = 1'b1; bus.load = 1'b0; bus.value_in = '0; bus.dp_in = '0; bus.blank_in = 1'b0;
        k = 0;
        repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        idle(40);

        to_phase(5);  load(16'h1234, 4'b0100); idle(40);
        to_phase(3);  load(16'h1111, 4'b0000); idle(3); load(16'h2222, 4'b0000); idle(40);

        to_phase(2);  load(16'hAAAA, 4'b0000);
        to_phase(FRAME - 1); load(16'h5678, 4'b0000); idle(40);

        to_phase(6);
        repeat (10) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
        idle(40);

        to_phase(4);  load(16'h0070, 4'b0000); idle(40);
        to_phase(4);  load(16'h0000, 4'b0100); idle(40);
        to_phase(4);  load(16'h0305, 4'b1000); idle(40);

        // Reset mid-frame with a value still pending.
        load(16'h9999, 4'b1111); idle(2);
        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        idle(40);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 499) == 0, $urandom_range(0, 7) == 0,
                 16'($urandom), 4'($urandom), $urandom_range(0, 9) == 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
